// File: rtl/dotproduct_sequencer.sv
// Control and feed sequencer for the dot-product datapath: CLEAR, LOAD, PREP, COMPUTE, DRAIN, DONE.
// Define DOTSEQ_ABORT_EN to add the abort input and the one-cycle ABORT cleanup state.
module dotproduct_sequencer #(
  parameter int Para_Deg         = 1,
  parameter int Data_Width_In    = 8,
  parameter int Data_Width_Out   = 16,
  parameter int Nums_SRAM_In     = 2,
  parameter int Nums_SRAM_Out    = 1,
  parameter int bits_Computation = 4,
  parameter int Nums_Computation = 1 << bits_Computation,
  parameter int Drain_Cycles     = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic accumulate,
`ifdef DOTSEQ_ABORT_EN
  input  logic abort,
`endif
  input  logic in_valid,
  output logic in_ready,
  input  logic [Para_Deg*Data_Width_In-1:0] in_data_a,
  input  logic [Para_Deg*Data_Width_In-1:0] in_data_b,
  output logic busy,
  output logic done,
  output logic Mem_reset,
  output logic Comp_reset,
  output logic Mem_Index_reset,
  output logic PE_reset,
  output logic Computing,
  output logic load_old_output,
  output logic load_from_file,
  output logic [Nums_SRAM_In*Para_Deg*Data_Width_In-1:0] input_data_from_file,
  output logic [Nums_SRAM_Out*Para_Deg*Data_Width_Out-1:0] output_data_from_file
);

  localparam int IW = Nums_SRAM_In * Para_Deg * Data_Width_In;
  localparam int CW = bits_Computation;
  localparam logic [CW-1:0] CNT_LAST = CW'(Nums_Computation - 1);
  localparam logic [3:0] DRAIN_LAST = 4'(Drain_Cycles - 1);

`ifdef DOTSEQ_ABORT_EN
  typedef enum logic [2:0] {
    IDLE, CLEAR, LOAD, PREP, COMPUTE, DRAIN, DONE, ABORT
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, CLEAR, LOAD, PREP, COMPUTE, DRAIN, DONE
  } state_t;
`endif

  state_t state;
  logic acc_q;
  logic load_last;
  logic [CW-1:0] beat_cnt;
  logic [CW-1:0] comp_cnt;
  logic [3:0] drain_cnt;

  assign output_data_from_file = '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      acc_q <= 1'b0;
      load_last <= 1'b0;
      beat_cnt <= '0;
      comp_cnt <= '0;
      drain_cnt <= '0;
      in_ready <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      Mem_reset <= 1'b0;
      Comp_reset <= 1'b0;
      Mem_Index_reset <= 1'b0;
      PE_reset <= 1'b0;
      Computing <= 1'b0;
      load_old_output <= 1'b0;
      load_from_file <= 1'b0;
      input_data_from_file <= '0;
    end
`ifdef DOTSEQ_ABORT_EN
    else if (abort && state != IDLE) begin
      state <= ABORT;
      load_last <= 1'b0;
      in_ready <= 1'b0;
      done <= 1'b0;
      Mem_reset <= 1'b0;
      Comp_reset <= 1'b1;
      Mem_Index_reset <= 1'b1;
      PE_reset <= 1'b1;
      Computing <= 1'b0;
      load_old_output <= 1'b0;
      load_from_file <= 1'b0;
    end
`endif
    else begin
      // single-cycle strobes default low
      done <= 1'b0;
      Mem_reset <= 1'b0;
      Comp_reset <= 1'b0;
      Mem_Index_reset <= 1'b0;
      PE_reset <= 1'b0;
      load_from_file <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= CLEAR;
            acc_q <= accumulate;
            busy <= 1'b1;
            Mem_reset <= ~accumulate;
            Comp_reset <= 1'b1;
            Mem_Index_reset <= 1'b1;
            PE_reset <= 1'b1;
          end
        end
        CLEAR: begin
          state <= LOAD;
          in_ready <= 1'b1;
          beat_cnt <= '0;
          load_last <= 1'b0;
        end
        LOAD: begin
          if (in_valid && in_ready) begin
            load_from_file <= 1'b1;
            input_data_from_file <= IW'({in_data_b, in_data_a});
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == CNT_LAST) begin
              in_ready <= 1'b0;
              load_last <= 1'b1;
            end
          end else if (load_last) begin
            // last beat's write cycle is done
            state <= PREP;
            load_last <= 1'b0;
            Comp_reset <= 1'b1;
            Mem_Index_reset <= 1'b1;
            PE_reset <= 1'b1;
            load_old_output <= acc_q;
          end
        end
        PREP: begin
          state <= COMPUTE;
          Computing <= 1'b1;
          comp_cnt <= '0;
        end
        COMPUTE: begin
          comp_cnt <= comp_cnt + 1'b1;
          if (comp_cnt == CNT_LAST) begin
            state <= DRAIN;
            Computing <= 1'b0;
            drain_cnt <= '0;
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + 1'b1;
          if (drain_cnt == DRAIN_LAST) begin
            state <= DONE;
            done <= 1'b1;
            busy <= 1'b0;
            load_old_output <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
        end
`ifdef DOTSEQ_ABORT_EN
        ABORT: begin
          state <= IDLE;
          busy <= 1'b0;
        end
`endif
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dotproduct_sequencer.sv
// Directed bench for dotproduct_sequencer: reset, loads, compute window, accumulate, start hold.
// Define DOTSEQ_ABORT_EN to also exercise the abort path.
module tb_dotproduct_sequencer;

  localparam int N = 16;
  localparam int D = 2;
  localparam int MAXC = 200;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic accumulate;
  logic in_valid;
  logic in_ready;
  logic [7:0] in_data_a;
  logic [7:0] in_data_b;
  logic busy;
  logic done;
  logic Mem_reset;
  logic Comp_reset;
  logic Mem_Index_reset;
  logic PE_reset;
  logic Computing;
  logic load_old_output;
  logic load_from_file;
  logic [15:0] input_data_from_file;
  logic [15:0] output_data_from_file;
`ifdef DOTSEQ_ABORT_EN
  logic abort;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dotproduct_sequencer dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .accumulate(accumulate),
`ifdef DOTSEQ_ABORT_EN
    .abort(abort),
`endif
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data_a(in_data_a),
    .in_data_b(in_data_b),
    .busy(busy),
    .done(done),
    .Mem_reset(Mem_reset),
    .Comp_reset(Comp_reset),
    .Mem_Index_reset(Mem_Index_reset),
    .PE_reset(PE_reset),
    .Computing(Computing),
    .load_old_output(load_old_output),
    .load_from_file(load_from_file),
    .input_data_from_file(input_data_from_file),
    .output_data_from_file(output_data_from_file)
  );

  logic lf_h [MAXC];
  logic cp_h [MAXC];
  logic lo_h [MAXC];
  logic bz_h [MAXC];
  logic rd_h [MAXC];
  logic mr_h [MAXC];
  logic mi_h [MAXC];
  logic [15:0] dat_h [MAXC];
  logic [15:0] od_h [MAXC];
  int ncyc;
  logic done_seen;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [41:0] all_outs();
    return {in_ready, busy, done, Mem_reset, Comp_reset, Mem_Index_reset,
            PE_reset, Computing, load_old_output, load_from_file,
            input_data_from_file, output_data_from_file};
  endfunction

  // Runs one job from start to the done cycle, recording outputs per cycle.
  // Cycle 0 is the CLEAR cycle.
  task automatic run_job(input logic acc, input bit toggle, input bit hold);
    int sent;
    bit acc_beat;
    sent = 0;
    ncyc = MAXC;
    done_seen = 1'b0;
    start = 1'b1;
    accumulate = acc;
    tick;
    if (!hold) start = 1'b0;
    for (int c = 0; c < MAXC; c++) begin
      lf_h[c] = load_from_file;
      cp_h[c] = Computing;
      lo_h[c] = load_old_output;
      bz_h[c] = busy;
      rd_h[c] = in_ready;
      mr_h[c] = Mem_reset;
      mi_h[c] = Mem_Index_reset;
      dat_h[c] = input_data_from_file;
      od_h[c] = output_data_from_file;
      if (done) begin
        ncyc = c + 1;
        done_seen = 1'b1;
        break;
      end
      in_valid = toggle ? (c % 2 == 1) : 1'b1;
      in_data_a = (sent < N) ? 8'(sent + 1) : 8'hEE;
      in_data_b = (sent < N) ? 8'd2 : 8'hEE;
      acc_beat = in_valid && in_ready;
      tick;
      if (acc_beat) sent++;
    end
    in_valid = 1'b0;
    chk("done_seen", done_seen, 1'b1);
    if (!hold) tick;
  endtask

  task automatic analyze(input string nm, input logic acc);
    int nw, w, bad, c0, c1, nc, dcyc, mrn, min_, ov, odb, lob, bzb, rdb;
    logic exp_lo;
    nw = 0; w = -1; bad = 0; c0 = -1; c1 = -1; nc = 0;
    mrn = 0; min_ = 0; ov = 0; odb = 0; lob = 0; bzb = 0; rdb = 0;
    dcyc = ncyc - 1;
    for (int c = 0; c < ncyc; c++) begin
      if (lf_h[c]) begin
        if (dat_h[c] !== {8'd2, 8'(nw + 1)}) bad++;
        nw++;
        w = c;
      end
      if (cp_h[c]) begin
        if (c0 < 0) c0 = c;
        c1 = c;
        nc++;
      end
      if (lf_h[c] && cp_h[c]) ov++;
      if (od_h[c] !== 16'h0) odb++;
      if (mr_h[c]) mrn++;
      if (mi_h[c]) min_++;
    end
    for (int c = 0; c < ncyc; c++) begin
      exp_lo = acc && (c > w) && (c < dcyc);
      if (lo_h[c] !== exp_lo) lob++;
      if (bz_h[c] !== (c < dcyc)) bzb++;
      if ((c == 0 || c >= w) && rd_h[c] !== 1'b0) rdb++;
    end
    chk({nm, "_writes"}, nw, N);
    chk({nm, "_write_data"}, bad, 0);
    chk({nm, "_mem_reset_cnt"}, mrn, acc ? 0 : 1);
    chk({nm, "_mem_reset_clear"}, mr_h[0], !acc);
    chk({nm, "_index_reset_cnt"}, min_, 2);
    chk({nm, "_compute_cnt"}, nc, N);
    chk({nm, "_compute_span"}, c1 - c0 + 1, N);
    chk({nm, "_compute_start"}, c0, w + 2);
    chk({nm, "_done_latency"}, dcyc, c1 + D + 1);
    chk({nm, "_overlap"}, ov, 0);
    chk({nm, "_out_data"}, odb, 0);
    chk({nm, "_load_old"}, lob, 0);
    chk({nm, "_busy"}, bzb, 0);
    chk({nm, "_ready_low"}, rdb, 0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    accumulate = 1'b0;
    in_valid = 1'b0;
    in_data_a = 8'h0;
    in_data_b = 8'h0;
`ifdef DOTSEQ_ABORT_EN
    abort = 1'b0;
`endif
    tick;
    tick;
    chk("reset_outputs", all_outs(), 42'h0);
    reset = 1'b0;
    tick;
    chk("idle_outputs", all_outs(), 42'h0);

    // reset in the middle of LOAD after five beats
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    chk("midload_ready", in_ready, 1'b1);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data_a = 8'(i + 1);
      in_data_b = 8'd2;
      tick;
    end
    in_valid = 1'b0;
    chk("midload_busy", busy, 1'b1);
    reset = 1'b1;
    #1;
    chk("midload_async_reset", all_outs(), 42'h0);
    tick;
    chk("midload_reset_outputs", all_outs(), 42'h0);
    reset = 1'b0;
    tick;

    run_job(1'b0, 1'b0, 1'b0);
    analyze("b2b", 1'b0);

    run_job(1'b0, 1'b1, 1'b0);
    analyze("toggle", 1'b0);

    run_job(1'b1, 1'b0, 1'b0);
    analyze("acc", 1'b1);

    // start held high through the whole job and the DONE cycle
    run_job(1'b0, 1'b0, 1'b1);
    analyze("hold", 1'b0);
    tick;
    chk("hold_idle_busy", busy, 1'b0);
    chk("hold_idle_index_reset", Mem_Index_reset, 1'b0);
    tick;
    chk("hold_restart_busy", busy, 1'b1);
    chk("hold_restart_index_reset", Mem_Index_reset, 1'b1);
    start = 1'b0;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    tick;

`ifdef DOTSEQ_ABORT_EN
    begin
      int ncomp;
      int ndone;
      bit ab_hit;
      ncomp = 0;
      ndone = 0;
      ab_hit = 1'b0;
      start = 1'b1;
      tick;
      start = 1'b0;
      for (int c = 0; c < MAXC && !ab_hit; c++) begin
        in_valid = 1'b1;
        in_data_a = 8'h11;
        in_data_b = 8'h22;
        if (Computing) ncomp++;
        if (ncomp == 7) begin
          abort = 1'b1;
          ab_hit = 1'b1;
        end
        tick;
      end
      in_valid = 1'b0;
      abort = 1'b0;
      chk("abort_reached", ab_hit, 1'b1);
      chk("abort_computing", Computing, 1'b0);
      chk("abort_index_reset", Mem_Index_reset, 1'b1);
      chk("abort_comp_reset", Comp_reset, 1'b1);
      chk("abort_pe_reset", PE_reset, 1'b1);
      chk("abort_mem_reset", Mem_reset, 1'b0);
      tick;
      chk("abort_idle_busy", busy, 1'b0);
      chk("abort_idle_resets", Mem_Index_reset, 1'b0);
      for (int c = 0; c < 30; c++) begin
        if (done) ndone++;
        tick;
      end
      chk("abort_no_done", ndone, 0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
